seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 18 +
 rtl/seg_scan_ctrl_bcd_to_seg.sv | 16 +
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and glyph constants for the 4-digit seven-segment scanner.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {g,f,e,d,c,b,a}, entry 9 first.
  localparam logic [9:0][6:0] GLYPH_TBL = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_seg.sv
// BCD to active-low seven-segment decode; codes 10-15 show a dash.
module bcd_to_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  localparam logic [6:0] DASH7 = SEG_DASH[6:0];

  always_comb begin
    seg_n = DASH7;
    if (bcd < 4'd10) seg_n = GLYPH_TBL[bcd];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scanner with blinking edit cursor.
// Optional leading-zero blanking: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_HALF = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        edit,
  input  logic        btn_sel,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  cursor
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  FRM_LAST = 8'(BLINK_HALF - 1);

  state_e      state_q;
  logic [15:0] scan_cnt_q;
  logic [1:0]  idx_q;
  logic [7:0]  frame_cnt_q;
  logic        blink_on_q;
  logic [1:0]  cursor_q;
  logic        edit_q;
  logic [3:0]  an_q;
  logic [7:0]  seg_q;

  logic [3:0] dig_sel;
  logic [6:0] glyph;
  logic [3:0] an_d;
  logic [7:0] seg_d;
  logic       cur_hit;
  logic       wrap;
  logic       frame_done;
  logic       edit_rise;
  logic       sel;

  always_comb begin
    dig_sel = digits[3:0];
    unique case (idx_q)
      2'd0: dig_sel = digits[3:0];
      2'd1: dig_sel = digits[7:4];
      2'd2: dig_sel = digits[11:8];
      2'd3: dig_sel = digits[15:12];
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (dig_sel),
    .seg_n (glyph)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [3:1] lz;
  logic       lz_blank;

  always_comb begin
    lz[3]    = (digits[15:12] == 4'd0);
    lz[2]    = lz[3] && (digits[11:8] == 4'd0);
    lz[1]    = lz[2] && (digits[7:4] == 4'd0);
    lz_blank = 1'b0;
    if (idx_q != 2'd0) lz_blank = lz[idx_q];
  end
`endif

  assign cur_hit    = edit && (idx_q == cursor_q);
  assign wrap       = (scan_cnt_q == CNT_LAST);
  assign frame_done = wrap && (idx_q == 2'd3);
  assign edit_rise  = edit && !edit_q;
  assign sel        = btn_sel && edit;
  assign an_d       = ~(4'b0001 << idx_q);

  always_comb begin
    seg_d = {1'b1, glyph};
    if (cur_hit) begin
      seg_d = blink_on_q ? {1'b0, glyph} : SEG_BLANK;
    end
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    else if (lz_blank) begin
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      cursor_q    <= '0;
      edit_q      <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= SEG_BLANK;
    end else begin
      edit_q <= edit;
      an_q   <= 4'hF;
      seg_q  <= SEG_BLANK;
      if (sel) cursor_q <= cursor_q + 2'd1;
      unique case (state_q)
        IDLE: begin
          if (en) state_q <= SCAN;
        end
        SCAN: begin
          if (!en) begin
            state_q     <= IDLE;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
          end else begin
            an_q       <= an_d;
            seg_q      <= seg_d;
            scan_cnt_q <= wrap ? '0 : scan_cnt_q + 16'd1;
            if (wrap) idx_q <= idx_q + 2'd1;
            if (frame_done) begin
              if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_q <= '0;
                blink_on_q  <= !blink_on_q;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
        end
      endcase
      // Any cursor action restarts the blink phase visibly lit.
      if (edit_rise || sel) begin
        blink_on_q  <= 1'b1;
        frame_cnt_q <= '0;
      end
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign cursor = cursor_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_HALF=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        edit;
  logic        btn_sel;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  cursor;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .SCAN_DIV   (4),
    .BLINK_HALF (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .edit    (edit),
    .btn_sel (btn_sel),
    .digits  (digits),
    .an      (an),
    .seg     (seg),
    .cursor  (cursor)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] ZERO_HI = 8'hFF;
`else
  localparam logic [7:0] ZERO_HI = 8'hC0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_frame(input string tag,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] want;
    logic [3:0] an_x;
    for (int i = 0; i < 16; i++) begin
      step();
      case (i / 4)
        0: want = s0;
        1: want = s1;
        2: want = s2;
        default: want = s3;
      endcase
      an_x = ~(4'b0001 << (i / 4));
      chk({tag, "_an"}, {4'h0, an}, {4'h0, an_x});
      chk({tag, "_seg"}, seg, want);
    end
  endtask

  task automatic restart();
    rst = 1'b1;
    step();
    chk("rst_an", {4'h0, an}, 8'h0F);
    rst = 1'b0;
    step();
    chk("entry_an", {4'h0, an}, 8'h0F);
  endtask

  initial begin
    logic [7:0] want;
    int f;
    int d;
    rst = 1'b1; en = 1'b0; edit = 1'b0;
    btn_sel = 1'b0; digits = 16'h0000;
    step();
    step();
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_cur", {6'h0, cursor}, 8'h00);

    // Plain scan of 1234.
    digits = 16'h1234;
    en = 1'b1;
    rst = 1'b0;
    step();
    chk("entry_an", {4'h0, an}, 8'h0F);
    chk_frame("scan1", 8'h99, 8'hB0, 8'hA4, 8'hF9);
    chk_frame("scan2", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Cursor ignores btn_sel outside edit.
    for (int i = 0; i < 4; i++) begin
      btn_sel = 1'b1; step(); btn_sel = 1'b0;
      chk("cur_noedit", {6'h0, cursor}, 8'h00);
    end
    edit = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      btn_sel = 1'b1; step(); btn_sel = 1'b0;
      chk("cur_edit", {6'h0, cursor}, 8'(i % 4));
    end
    for (int i = 0; i < 2; i++) begin
      btn_sel = 1'b1; step(); btn_sel = 1'b0;
    end
    chk("cur_two", {6'h0, cursor}, 8'h02);

    // Reset mid-edit.
    rst = 1'b1;
    step();
    chk("rst_cur", {6'h0, cursor}, 8'h00);
    chk("rst_an2", {4'h0, an}, 8'h0F);
    chk("rst_seg2", seg, 8'hFF);
    rst = 1'b0;
    step();
    chk("rst_rel1", {4'h0, an}, 8'h0F);
    step();
    chk("rst_rel2", {4'h0, an}, 8'h0E);
    chk("rst_rel2_seg", seg, 8'h19);

    // Blink of cursor digit 0, two frames per half-period.
    restart();
    for (int n = 0; n < 96; n++) begin
      step();
      f = n / 16;
      d = (n % 16) / 4;
      case (d)
        0: want = ((f / 2) % 2 == 0) ? 8'h19 : 8'hFF;
        1: want = 8'hB0;
        2: want = 8'hA4;
        default: want = 8'hF9;
      endcase
      chk("blink_seg", seg, want);
      chk("blink_an", {4'h0, an}, {4'h0, ~(4'b0001 << d)});
    end

    // Invalid codes.
    edit = 1'b0;
    digits = 16'h00AF;
    restart();
    chk_frame("dash", 8'hBF, 8'hBF, ZERO_HI, ZERO_HI);

    // Enable dropped mid-dwell, then restart at digit 0.
    step();
    step();
    en = 1'b0;
    step();
    chk("endrop_an", {4'h0, an}, 8'h0F);
    chk("endrop_seg", seg, 8'hFF);
    en = 1'b1;
    step();
    chk("enre1_an", {4'h0, an}, 8'h0F);
    step();
    chk("enre2_an", {4'h0, an}, 8'h0E);
    chk("enre2_seg", seg, 8'hBF);

    // Digits change mid-dwell.
    digits = 16'h00A5;
    step();
    chk("mid_an", {4'h0, an}, 8'h0E);
    chk("mid_seg", seg, 8'h92);

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    digits = 16'h0050;
    restart();
    chk_frame("lzb", 8'hC0, 8'h92, 8'hFF, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
